// File: rtl/adc_display_driver.sv
// Four-digit common-anode seven-segment driver for the ADC conversion word.
// Latches the word at a slow update rate and scans its nibbles onto the digits.
module adc_display_driver #(
  parameter int REFRESH_COUNT = 100000,
  parameter int UPDATE_COUNT  = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adc_value,
  input  logic        hold,
  input  logic        blank_en,
  input  logic        dp_en,
  input  logic [1:0]  dp_sel,
  output logic [3:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        update_pulse
);

  localparam int REF_W = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam int UPD_W = (UPDATE_COUNT > 2) ? $clog2(UPDATE_COUNT) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_COUNT - 1);
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_COUNT - 1);

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [REF_W-1:0] ref_cnt_p0;
  logic [UPD_W-1:0] upd_cnt_p0;
  logic [1:0]       digit_sel_p0;
  logic [15:0]      disp_reg_p0;

  logic             ref_tc_p0;
  logic             upd_tc_p0;
  logic             load_p0;
  logic [3:0]       nibble_p0;
  logic [3:0]       lead_zero_p0;
  logic             keep_p0;
  logic             blank_p0;
  logic [3:0]       anode_p0;
  logic [6:0]       seg_p0;
  logic             dp_p0;

  // stage p0: counters, display register and combinational digit decode
  always_comb begin
    ref_tc_p0 = (ref_cnt_p0 == REF_LAST);
    upd_tc_p0 = (upd_cnt_p0 == UPD_LAST);
    load_p0   = upd_tc_p0 && !hold;

    nibble_p0 = disp_reg_p0[{digit_sel_p0, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    lead_zero_p0    = 4'b0000;
    lead_zero_p0[3] = (disp_reg_p0[15:12] == 4'h0);
    lead_zero_p0[2] = lead_zero_p0[3] && (disp_reg_p0[11:8] == 4'h0);
    lead_zero_p0[1] = lead_zero_p0[2] && (disp_reg_p0[7:4] == 4'h0);

    // Digits from the decimal point rightwards stay lit so "0.05" keeps its zeros.
    keep_p0  = dp_en && (digit_sel_p0 <= dp_sel);
    blank_p0 = blank_en && lead_zero_p0[digit_sel_p0] && !keep_p0;

    anode_p0 = ~(4'b0001 << digit_sel_p0);
    seg_p0   = blank_p0 ? 7'h7F : hex_to_seg(nibble_p0);
    dp_p0    = !(dp_en && (digit_sel_p0 == dp_sel));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_p0   <= '0;
      upd_cnt_p0   <= '0;
      digit_sel_p0 <= 2'd0;
      disp_reg_p0  <= 16'h0000;
    end else begin
      ref_cnt_p0 <= ref_tc_p0 ? '0 : ref_cnt_p0 + 1'b1;
      upd_cnt_p0 <= upd_tc_p0 ? '0 : upd_cnt_p0 + 1'b1;
      if (ref_tc_p0) digit_sel_p0 <= digit_sel_p0 + 2'd1;
      if (load_p0)   disp_reg_p0  <= adc_value;
    end
  end

  // stage p1: registered active-low pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_n      <= 4'b1111;
      seg_n        <= 7'h7F;
      dp_n         <= 1'b1;
      update_pulse <= 1'b0;
    end else begin
      anode_n      <= anode_p0;
      seg_n        <= seg_p0;
      dp_n         <= dp_p0;
      update_pulse <= load_p0;
    end
  end

endmodule

// File: tb/tb_adc_display_driver.sv
// Directed bench for adc_display_driver: expected digit patterns are queued
// when a value is scheduled for display and compared as the scan shows them.
module tb_adc_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] adc_value = 16'h0000;
  logic        hold = 1'b0;
  logic        blank_en = 1'b1;
  logic        dp_en = 1'b0;
  logic [1:0]  dp_sel = 2'd0;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        update_pulse;

  adc_display_driver #(.REFRESH_COUNT(4), .UPDATE_COUNT(32)) dut (
    .clk(clk), .reset(reset), .adc_value(adc_value), .hold(hold),
    .blank_en(blank_en), .dp_en(dp_en), .dp_sel(dp_sel),
    .anode_n(anode_n), .seg_n(seg_n), .dp_n(dp_n), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;
  int c0;
  int np;

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic [15:0] v, input logic b, input logic de,
                             input logic [1:0] ds);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      logic blank;
      logic [3:0] nib;
      nib   = v[4*i +: 4];
      blank = b && (i != 0) && ((v >> (4*i)) == 16'h0) && !(de && (i <= int'(ds)));
      e.an    = 4'b1111;
      e.an[i] = 1'b0;
      e.seg   = blank ? 7'h7F : seg_tab[nib];
      e.dp    = !(de && (i == int'(ds)));
      sb.push_back(e);
    end
  endtask

  // Align to a digit-0 window, then sample each digit once as it is lit.
  task automatic scan_compare(input string tag);
    int n = 0;
    while (anode_n !== 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sync"}, {28'h0, anode_n}, 32'h0000000E);
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("%s_an%0d", tag, d), {28'h0, anode_n}, {28'h0, e.an});
      chk($sformatf("%s_seg%0d", tag, d), {25'h0, seg_n}, {25'h0, e.seg});
      chk($sformatf("%s_dp%0d", tag, d), {31'h0, dp_n}, {31'h0, e.dp});
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (update_pulse !== 1'b1 && n < budget);
    chk({tag, "_pulse"}, {31'h0, update_pulse}, 32'h1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"}, {28'h0, anode_n}, 32'hF);
    chk({tag, "_seg"}, {25'h0, seg_n}, 32'h7F);
    chk({tag, "_dp"}, {31'h0, dp_n}, 32'h1);
    chk({tag, "_upd"}, {31'h0, update_pulse}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, release with 1234 pending
    adc_value = 16'h1234;
    repeat (3) @(negedge clk);
    check_reset_state("rst1");
    reset = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk("rel1_an", {28'h0, anode_n}, 32'hE);
    chk("rel1_seg", {25'h0, seg_n}, 32'h40);
    push_expect(16'h0000, 1'b1, 1'b0, 2'd0);
    scan_compare("zero1");
    wait_pulse("t1", 40);
    chk("t1_latency", cyc - c0, 32);
    push_expect(16'h1234, 1'b1, 1'b0, 2'd0);
    scan_compare("v1234");

    // 2: leading-zero blanking on and off without a reload
    adc_value = 16'h00A7;
    wait_pulse("t2", 40);
    push_expect(16'h00A7, 1'b1, 1'b0, 2'd0);
    scan_compare("a7_blank");
    blank_en = 1'b0;
    push_expect(16'h00A7, 1'b0, 1'b0, 2'd0);
    scan_compare("a7_noblank");

    // 3: decimal point protects zeros to its right
    blank_en = 1'b1;
    dp_en = 1'b1;
    dp_sel = 2'd2;
    adc_value = 16'h0005;
    wait_pulse("t3", 40);
    push_expect(16'h0005, 1'b1, 1'b1, 2'd2);
    scan_compare("dp005");

    // 4: hold freezes the display register
    dp_en = 1'b0;
    adc_value = 16'h1111;
    wait_pulse("t4a", 40);
    push_expect(16'h1111, 1'b1, 1'b0, 2'd0);
    scan_compare("h1111");
    hold = 1'b1;
    adc_value = 16'h2222;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (update_pulse === 1'b1) np++;
    end
    chk("hold_no_pulse", np, 0);
    push_expect(16'h1111, 1'b1, 1'b0, 2'd0);
    scan_compare("held");
    hold = 1'b0;
    wait_pulse("t4b", 40);
    push_expect(16'h2222, 1'b1, 1'b0, 2'd0);
    scan_compare("h2222");

    // 5: one-cycle reset while digit 2 is lit
    np = 0;
    while (anode_n !== 4'b1011 && np < 20) begin
      @(negedge clk);
      np++;
    end
    chk("t5_dig2", {28'h0, anode_n}, 32'hB);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rst5");
    reset = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk("rel5_an", {28'h0, anode_n}, 32'hE);
    chk("rel5_seg", {25'h0, seg_n}, 32'h40);
    push_expect(16'h0000, 1'b1, 1'b0, 2'd0);
    scan_compare("zero5");
    adc_value = 16'h0123;
    wait_pulse("t5", 40);
    chk("t5_latency", cyc - c0, 32);

    // 6: hex sweep, including 0123 just loaded
    @(negedge clk);
    chk("w0123", {31'h0, update_pulse}, 32'h0);
    push_expect(16'h0123, 1'b1, 1'b0, 2'd0);
    scan_compare("s0123");
    adc_value = 16'h4567;
    wait_pulse("t6a", 40);
    @(negedge clk);
    chk("w4567", {31'h0, update_pulse}, 32'h0);
    push_expect(16'h4567, 1'b1, 1'b0, 2'd0);
    scan_compare("s4567");
    adc_value = 16'h89AB;
    wait_pulse("t6b", 40);
    @(negedge clk);
    chk("w89ab", {31'h0, update_pulse}, 32'h0);
    push_expect(16'h89AB, 1'b1, 1'b0, 2'd0);
    scan_compare("s89ab");
    adc_value = 16'hCDEF;
    wait_pulse("t6c", 40);
    @(negedge clk);
    chk("wcdef", {31'h0, update_pulse}, 32'h0);
    push_expect(16'hCDEF, 1'b1, 1'b0, 2'd0);
    scan_compare("scdef");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
